// File: rtl/ram_n.sv
// DEPTH x WIDTH word memory with Hack-style RAMn semantics and a post-reset clear sweep.
// Define RAM_N_READ_REG_EN for a registered (1-cycle, write-first) read port.
module ram_n #(
    parameter  int WIDTH  = 16,
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    output logic [WIDTH-1:0]  out,
    output logic              busy
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [WIDTH-1:0]  r_mem [DEPTH];

    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic              w_addr_ok;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [WIDTH-1:0]  w_wdata;
    logic [WIDTH-1:0]  w_rd_word;

    assign busy      = (r_state == S_CLEAR);
    assign w_addr_ok = ({1'b0, address} < DEPTH_W);
    assign w_rd_word = w_addr_ok ? r_mem[address] : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_clr_ptr;
        if (reset) begin
            w_state_nxt = S_CLEAR;
            w_ptr_nxt   = '0;
        end else if (r_state == S_CLEAR) begin
            if (r_clr_ptr == LAST_PTR) begin
                w_state_nxt = S_IDLE;
                w_ptr_nxt   = '0;
            end else begin
                w_ptr_nxt = r_clr_ptr + 1'b1;
            end
        end
    end

    // Single write port shared by the clear sweep and user writes.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = address;
        w_wdata = in;
        if (!reset) begin
            if (r_state == S_CLEAR) begin
                w_we    = 1'b1;
                w_waddr = r_clr_ptr;
                w_wdata = '0;
            end else begin
                w_we = load && w_addr_ok;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_ptr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
    end

`ifdef RAM_N_READ_REG_EN
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_rd_next;

    // Write-first: a same-edge write to the read address is forwarded.
    always_comb begin
        w_rd_next = w_rd_word;
        if (w_we && (w_waddr == address))
            w_rd_next = w_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_out <= '0;
        else if ((w_state_nxt == S_CLEAR) || !w_addr_ok)
            r_out <= '0;
        else
            r_out <= w_rd_next;
    end

    assign out = r_out;
`else
    assign out = busy ? '0 : w_rd_word;
`endif

endmodule

// File: tb/tb_ram_n.sv
// Directed bench for ram_n: clear sweep, writes, busy masking, reset restart, out-of-range.
module tb_ram_n;

    logic        clk;
    logic        rst8, load8, busy8;
    logic [15:0] din8, out8;
    logic [2:0]  addr8;
    logic        rst6, load6, busy6;
    logic [15:0] din6, out6;
    logic [2:0]  addr6;

    int checks;
    int failures;

    ram_n #(.WIDTH(16), .DEPTH(8)) dut8 (
        .clk(clk), .reset(rst8), .in(din8), .load(load8),
        .address(addr8), .out(out8), .busy(busy8)
    );

    ram_n #(.WIDTH(16), .DEPTH(6)) dut6 (
        .clk(clk), .reset(rst6), .in(din6), .load(load6),
        .address(addr6), .out(out6), .busy(busy6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd8(input logic [2:0] a, output logic [15:0] v);
        addr8 = a;
`ifdef RAM_N_READ_REG_EN
        tick();
`else
        #1;
`endif
        v = out8;
    endtask

    task automatic rd6(input logic [2:0] a, output logic [15:0] v);
        addr6 = a;
`ifdef RAM_N_READ_REG_EN
        tick();
`else
        #1;
`endif
        v = out6;
    endtask

    task automatic test_reset();
        rst8 = 1'b1; load8 = 1'b0; din8 = '0; addr8 = '0;
        tick();
        checks++;
        if (busy8 !== 1'b1) begin
            failures++; $display("FAIL reset_busy got=%b exp=1", busy8);
        end
        checks++;
        if (out8 !== 16'h0000) begin
            failures++; $display("FAIL reset_out got=%h exp=0000", out8);
        end
        tick(); tick();
        checks++;
        if (busy8 !== 1'b1) begin
            failures++; $display("FAIL held_reset_busy got=%b exp=1", busy8);
        end
    endtask

    task automatic test_clear_sweep();
        int n;
        logic [15:0] v;
        rst8 = 1'b0;
        load8 = 1'b1; addr8 = 3'd5; din8 = 16'h1234;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (busy8 !== 1'b1) break;
            checks++;
            if (out8 !== 16'h0000) begin
                failures++; $display("FAIL busy_out_forced got=%h exp=0000", out8);
            end
        end
        load8 = 1'b0; din8 = '0;
        checks++;
        if (n != 8) begin
            failures++; $display("FAIL sweep_len got=%0d exp=8", n);
        end
        for (int a = 0; a < 8; a++) begin
            rd8(3'(a), v);
            checks++;
            if (v !== 16'h0000) begin
                failures++; $display("FAIL cleared_word addr=%0d got=%h exp=0000", a, v);
            end
        end
    endtask

    task automatic test_write_read();
        logic [15:0] v;
        addr8 = 3'd3; din8 = 16'hBEEF; load8 = 1'b1;
        tick();
        load8 = 1'b0;
        checks++;
        if (out8 !== 16'hBEEF) begin
            failures++; $display("FAIL write_post_edge got=%h exp=beef", out8);
        end
        rd8(3'd3, v);
        checks++;
        if (v !== 16'hBEEF) begin
            failures++; $display("FAIL read_addr3 got=%h exp=beef", v);
        end
        rd8(3'd2, v);
        checks++;
        if (v !== 16'h0000) begin
            failures++; $display("FAIL read_addr2 got=%h exp=0000", v);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_v [4];
        logic [15:0] v;
        exp_v[0] = 16'h1111; exp_v[1] = 16'h2222; exp_v[2] = 16'h3333; exp_v[3] = 16'hBEEF;
        load8 = 1'b1;
        for (int a = 0; a < 3; a++) begin
            addr8 = 3'(a); din8 = exp_v[a];
            tick();
        end
        load8 = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd8(3'(a), v);
            checks++;
            if (v !== exp_v[a]) begin
                failures++; $display("FAIL b2b addr=%0d got=%h exp=%h", a, v, exp_v[a]);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        logic [15:0] v;
        rst8 = 1'b1; tick(); rst8 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (busy8 !== 1'b1) begin
            failures++; $display("FAIL mid_sweep_busy got=%b exp=1", busy8);
        end
        rst8 = 1'b1; tick(); rst8 = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (busy8 !== 1'b1) break;
        end
        checks++;
        if (n != 8) begin
            failures++; $display("FAIL restart_sweep_len got=%0d exp=8", n);
        end
        rd8(3'd3, v);
        checks++;
        if (v !== 16'h0000) begin
            failures++; $display("FAIL restart_cleared got=%h exp=0000", v);
        end
        rd8(3'd7, v);
        checks++;
        if (v !== 16'h0000) begin
            failures++; $display("FAIL restart_cleared_last got=%h exp=0000", v);
        end
    endtask

    task automatic test_out_of_range();
        int n;
        logic [15:0] v;
        rst6 = 1'b1; load6 = 1'b0; din6 = '0; addr6 = '0;
        tick(); rst6 = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (busy6 !== 1'b1) break;
        end
        checks++;
        if (n != 6) begin
            failures++; $display("FAIL d6_sweep_len got=%0d exp=6", n);
        end
        addr6 = 3'd2; din6 = 16'h0A0A; load6 = 1'b1;
        tick();
        addr6 = 3'd7; din6 = 16'hFFFF;
        tick();
        load6 = 1'b0;
        checks++;
        if (out6 !== 16'h0000) begin
            failures++; $display("FAIL oor_out got=%h exp=0000", out6);
        end
        for (int a = 0; a < 7; a++) begin
            rd6(3'(a), v);
            checks++;
            if (v !== ((a == 2) ? 16'h0A0A : 16'h0000)) begin
                failures++; $display("FAIL oor_word addr=%0d got=%h", a, v);
            end
        end
    endtask

    task automatic test_read_port();
        addr8 = 3'd1; din8 = 16'h00A5; load8 = 1'b1;
        tick();
        load8 = 1'b0;
        addr8 = 3'd4;
        tick();
        addr8 = 3'd1;
        #1;
`ifdef RAM_N_READ_REG_EN
        checks++;
        if (out8 !== 16'h0000) begin
            failures++; $display("FAIL rdreg_before_edge got=%h exp=0000", out8);
        end
        tick();
        checks++;
        if (out8 !== 16'h00A5) begin
            failures++; $display("FAIL rdreg_after_edge got=%h exp=00a5", out8);
        end
`else
        checks++;
        if (out8 !== 16'h00A5) begin
            failures++; $display("FAIL comb_read got=%h exp=00a5", out8);
        end
`endif
        din8 = 16'h5A00; load8 = 1'b1;
        tick();
        load8 = 1'b0;
        checks++;
        if (out8 !== 16'h5A00) begin
            failures++; $display("FAIL write_first got=%h exp=5a00", out8);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst6 = 1'b1; load6 = 1'b0; din6 = '0; addr6 = '0;
        test_reset();
        test_clear_sweep();
        test_write_read();
        test_back_to_back();
        test_reset_mid_sweep();
        test_read_port();
        test_out_of_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_n.md
Name: ram_n

Overview:
- Parametrised successor to the single-bit DFF/Bit/Register chain.
- A DEPTH x WIDTH word memory with Hack-style RAMn semantics:
  - write on the clock edge when load is high;
  - out reflects RAM[address].
- Adds a reset-driven clear sequencer that zeroes every word after reset, flagged by busy.
- Sits as the common base under the RAM8/RAM64/RAM512/RAM4K/RAM16K instances of the sequential-chips project.

Parameters:
- WIDTH, 16, data word width in bits (>=1).
- DEPTH, 8, number of words (>=2; power of two not required).
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden by users.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
- in  input  WIDTH  write data.
- load  input  1  write enable.
- address  input  ADDR_W  read/write word address.
- out  output  WIDTH  read data.
- busy  output  1  high while clear sweep in progress; accesses ignored.

Behaviour:
- States: IDLE, CLEAR. Clear pointer clr_ptr (ADDR_W bits).
- Reset asserted at an edge:
  - state <= CLEAR, clr_ptr <= 0, no write from in/load that cycle;
  - busy=1 from that edge;
  - held reset keeps clr_ptr at 0 and state in CLEAR.
- CLEAR, reset low:
  - each edge writes 0 to RAM[clr_ptr], clr_ptr <= clr_ptr+1;
  - on the edge that writes word DEPTH-1: state <= IDLE, busy <= 0, clr_ptr <= 0.
  - Sweep therefore takes exactly DEPTH edges after reset deasserts.
- Reset reasserted mid-sweep: sweep restarts from clr_ptr=0. Already-cleared words remain 0.
- While busy=1:
  - load ignored (no user write);
  - out forced to 0.
- IDLE:
  - load=1 at edge with address<DEPTH: RAM[address] <= in;
  - load=1 with address>=DEPTH: no write, no side effect.
- Read (default build):
  - out = RAM[address] combinationally when busy=0 and address<DEPTH;
  - out = 0 when address>=DEPTH.
  - Write then read same address: out shows new value immediately after the write edge (no read-during-write old-data hazard observable on out, since read is post-edge).
- Reset values:
  - busy=1 after reset edge;
  - out=0 while busy;
  - all words = 0 once busy falls.
- Memory contents before the first reset are undefined. Bench must reset first.
- No arithmetic beyond clr_ptr increment. clr_ptr never wraps past DEPTH-1.

Optional Feature:
- Macro: RAM_N_READ_REG_EN
- Defined: out is registered.
  - At each edge: out <= (busy_next or address>=DEPTH) ? 0 : RAM_next[address], where RAM_next includes a write on that same edge (write-first).
  - Read latency: 1 cycle from address presentation.
  - out resets to 0 on the reset edge.
- Undefined: combinational read as above; zero-latency.

Test Plan:
- Clear sweep: DEPTH=8, pulse reset 1 cycle → busy=1 for exactly 8 edges after deassert, then 0; reading addresses 0..7 returns 0x0000.
- Write/read: after clear, load=1 address=3 in=0xBEEF one edge, then load=0 → out=0xBEEF at address 3. Address 2 still reads 0x0000.
- Load ignored while busy: assert load=1 address=5 in=0x1234 during the sweep → after busy falls, address 5 reads 0x0000.
- Reset mid-sweep: reset again after 4 sweep edges → busy stays 1 for a further 8 edges after deassert. Total busy period restarts.
- Out-of-range: DEPTH=6, after clear write address=7 in=0xFFFF → no word changes (addresses 0..5 read 0), out=0 at address 7.
- RAM_N_READ_REG_EN defined: write 0x00A5 to address 1, then set address=1 → out=0x00A5 one edge later, 0 before. Same-edge write+read at address 1 of 0x5A00 → out=0x5A00 after that edge.
